// File: rtl/img_ram_pkg.sv
// Shared types and defaults for the latency-modelled image buffer.
package img_ram_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   localparam int MISS_DELAY_DEF = 7;
   localparam int COL_W_DEF      = 8;

endpackage

// File: rtl/img_ram_if.sv
// Port A handshake, port B plain access and the profiling counters.
interface img_ram_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 19,
   parameter int CNT_W  = 16
);
   logic              a_req;
   logic              a_we;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_wdata;
   logic              a_ready;
   logic              a_done;
   logic [DATA_W-1:0] a_rdata;
   logic              b_we;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_wdata;
   logic [DATA_W-1:0] b_rdata;
   logic [CNT_W-1:0]  hit_cnt;
   logic [CNT_W-1:0]  miss_cnt;

   modport master (
      output a_req, a_we, a_addr, a_wdata, b_we, b_addr, b_wdata,
      input  a_ready, a_done, a_rdata, b_rdata, hit_cnt, miss_cnt
   );

   modport slave (
      input  a_req, a_we, a_addr, a_wdata, b_we, b_addr, b_wdata,
      output a_ready, a_done, a_rdata, b_rdata, hit_cnt, miss_cnt
   );
endinterface

// File: rtl/img_ram_core.sv
// True dual-port word array. Port A wins a same-address write collision;
// out-of-range writes are dropped and out-of-range reads return zero.
module img_ram_core #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 19,
   parameter int DEPTH  = 263169
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_en,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic [DATA_W-1:0] b_rdata
);

   localparam logic [31:0] DEPTH_U = 32'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic a_ok, b_ok, a_wr, b_wr;

   assign a_ok = 32'(a_addr) < DEPTH_U;
   assign b_ok = 32'(b_addr) < DEPTH_U;
   assign a_wr = a_en && a_we && a_ok;
   assign b_wr = b_we && b_ok && !(a_wr && (a_addr == b_addr));

   // Array writes; contents are deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (a_wr) mem[a_addr] <= a_wdata;
      if (b_wr) mem[b_addr] <= b_wdata;
   end

   // Registered read ports; reads see the pre-edge contents, writes echo data.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_rdata <= '0;
         b_rdata <= '0;
      end else begin
         if (a_en) a_rdata <= a_we ? a_wdata : (a_ok ? mem[a_addr] : '0);
         b_rdata <= b_we ? b_wdata : (b_ok ? mem[b_addr] : '0);
      end
   end

endmodule

// File: rtl/img_ram_lat.sv
// Image buffer with an open-row latency model on port A: a hit completes the
// cycle after accept, a row change stalls for MISS_DELAY extra cycles.
module img_ram_lat
   import img_ram_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int ADDR_W     = 19,
   parameter int DEPTH      = 263169,
   parameter int COL_W      = COL_W_DEF,
   parameter int MISS_DELAY = MISS_DELAY_DEF,
   parameter int CNT_W      = 16
) (
   input logic     clk,
   input logic     rst,
   img_ram_if.slave bus
);

   localparam int ROW_W = ADDR_W - COL_W;
   localparam int WC_W  = $clog2(MISS_DELAY + 1);

   state_t            state, state_nx;
   logic [WC_W-1:0]   wcnt;
   logic [ROW_W-1:0]  open_row;
   logic              open_valid;
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic              accept, hit, finish, fire;
   logic              m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;

   assign bus.a_ready = (state == IDLE) && !rst;

   // Next state plus accept/hit/finish decode for the current cycle.
   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      hit      = 1'b0;
      finish   = 1'b0;
      case (state)
         IDLE: if (bus.a_req && !rst) begin
            accept = 1'b1;
            hit    = open_valid && (bus.a_addr[ADDR_W-1:COL_W] == open_row);
            if (!hit) state_nx = WAIT;
         end
         WAIT: if (wcnt == WC_W'(1)) begin
            finish   = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // A reset mid-WAIT must not let the pending access reach the array.
   assign fire    = (accept && hit) || (finish && !rst);
   assign m_we    = (state == IDLE) ? bus.a_we    : lat_we;
   assign m_addr  = (state == IDLE) ? bus.a_addr  : lat_addr;
   assign m_wdata = (state == IDLE) ? bus.a_wdata : lat_wdata;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Request latch, miss countdown, open-row tracker and saturating counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         wcnt         <= '0;
         open_valid   <= 1'b0;
         open_row     <= '0;
         bus.a_done   <= 1'b0;
         bus.hit_cnt  <= '0;
         bus.miss_cnt <= '0;
      end else begin
         bus.a_done <= fire;
         if (accept) begin
            lat_we    <= bus.a_we;
            lat_addr  <= bus.a_addr;
            lat_wdata <= bus.a_wdata;
            if (hit) begin
               if (~&bus.hit_cnt) bus.hit_cnt <= bus.hit_cnt + 1'b1;
            end else begin
               if (~&bus.miss_cnt) bus.miss_cnt <= bus.miss_cnt + 1'b1;
               wcnt <= WC_W'(MISS_DELAY);
            end
         end
         if (state == WAIT) wcnt <= wcnt - 1'b1;
         if (finish) begin
            open_row   <= lat_addr[ADDR_W-1:COL_W];
            open_valid <= 1'b1;
         end
      end
   end

   img_ram_core #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_core (
      .clk     (clk),
      .rst     (rst),
      .a_en    (fire),
      .a_we    (m_we),
      .a_addr  (m_addr),
      .a_wdata (m_wdata),
      .a_rdata (bus.a_rdata),
      .b_we    (bus.b_we),
      .b_addr  (bus.b_addr),
      .b_wdata (bus.b_wdata),
      .b_rdata (bus.b_rdata)
   );

endmodule
